// File: rtl/sobel_window.sv
// -----------------------------------------------------------------------------
// sobel_window
//
// Streaming 3x3 neighbourhood generator. It takes a raster-order 8-bit pixel
// stream and produces one registered 3x3 window per accepted pixel once a full
// neighbourhood exists. Two line buffers hold the previous two image rows, and
// a 3x3 shift-register window holds the neighbourhood itself.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   pixel qualifier, one pixel accepted per cycle while high
//   in_sof     start of frame, qualified by in_valid; forces pixel (0,0)
//   in_pixel   8-bit pixel data, raster order (x fastest)
//   out_valid  one-cycle pulse, new window present on p0..p8
//   p0..p2     top row    (x-2..x, y-2)
//   p3..p5     middle row (x-2..x, y-1); p4 is the centre pixel
//   p6..p8     bottom row (x-2..x, y)
//   out_last   high with out_valid on the final window of a frame
// -----------------------------------------------------------------------------
module sobel_window #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_sof,
    input  logic [7:0] in_pixel,
    output logic       out_valid,
    output logic [7:0] p0,
    output logic [7:0] p1,
    output logic [7:0] p2,
    output logic [7:0] p3,
    output logic [7:0] p4,
    output logic [7:0] p5,
    output logic [7:0] p6,
    output logic [7:0] p7,
    output logic [7:0] p8,
    output logic       out_last
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_TWO  = XW'(2);
    localparam logic [YW-1:0] Y_TWO  = YW'(2);

    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;

    // Effective coordinates of the pixel presented this cycle; in_sof
    // overrides the running counters so a mid-frame abort resyncs at once.
    logic [XW-1:0] col;
    logic [YW-1:0] row;

    logic [7:0] lb_mid [IMG_W];
    logic [7:0] lb_top [IMG_W];

    logic [7:0] mid_new;
    logic [7:0] top_new;

    logic       col_last;
    logic       row_last;
    logic       win_ok;
    logic       frame_end;

    always_comb begin
        col = x_cnt;
        row = y_cnt;
        if (in_sof) begin
            col = '0;
            row = '0;
        end
    end

    assign col_last  = (col == X_LAST);
    assign row_last  = (row == Y_LAST);
    assign win_ok    = (col >= X_TWO) && (row >= Y_TWO);
    assign frame_end = col_last && row_last;

    // Asynchronous reads: the old contents are sampled before the write
    // below lands on the same edge, which gives read-before-write for free.
    assign mid_new = lb_mid[col];
    assign top_new = lb_top[col];

    // Line buffers are not reset; every location is rewritten in the current
    // frame before the window logic can expose it.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb_top[col] <= mid_new;
            lb_mid[col] <= in_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (in_valid) begin
            if (col_last) begin
                x_cnt <= '0;
                y_cnt <= row_last ? '0 : row + 1'b1;
            end else begin
                x_cnt <= col + 1'b1;
                y_cnt <= row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            p0 <= 8'h00;
            p1 <= 8'h00;
            p2 <= 8'h00;
            p3 <= 8'h00;
            p4 <= 8'h00;
            p5 <= 8'h00;
            p6 <= 8'h00;
            p7 <= 8'h00;
            p8 <= 8'h00;
        end else if (in_valid) begin
            out_valid <= win_ok;
            out_last  <= frame_end;
            p0 <= p1;
            p1 <= p2;
            p2 <= top_new;
            p3 <= p4;
            p4 <= p5;
            p5 <= mid_new;
            p6 <= p7;
            p7 <= p8;
            p8 <= in_pixel;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_window.sv
// -----------------------------------------------------------------------------
// tb_sobel_window
//
// Directed bench for sobel_window on a 4x3 image. Windows seen on the outputs
// are captured into a queue and compared against windows extracted from the
// stimulus image arrays.
// -----------------------------------------------------------------------------
module tb_sobel_window;

    localparam int W = 4;
    localparam int H = 3;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_sof;
    logic [7:0] in_pixel;
    logic       out_valid;
    logic       out_last;
    logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;

    int errors = 0;
    int checks = 0;

    logic [7:0]  img [0:4][0:H-1][0:W-1];
    logic [72:0] cap [$];
    logic [72:0] exp_q [$];

    sobel_window #(.IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .p0        (p0),
        .p1        (p1),
        .p2        (p2),
        .p3        (p3),
        .p4        (p4),
        .p5        (p5),
        .p6        (p6),
        .p7        (p7),
        .p8        (p8),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid)
            cap.push_back({out_last, p0, p1, p2, p3, p4, p5, p6, p7, p8});
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step(input bit v, input bit s, input logic [7:0] d);
        in_valid = v;
        in_sof   = s;
        in_pixel = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [72:0] win(input int f, input int x, input int y);
        return {((x == W-1) && (y == H-1)) ? 1'b1 : 1'b0,
                img[f][y-2][x-2], img[f][y-2][x-1], img[f][y-2][x],
                img[f][y-1][x-2], img[f][y-1][x-1], img[f][y-1][x],
                img[f][y][x-2],   img[f][y][x-1],   img[f][y][x]};
    endfunction

    // gap_mode: 0 continuous, 1 one idle cycle after each pixel, 2 random idles
    task automatic send_frame(input int f, input bit sof_first, input int gap_mode);
        int n;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                step(1'b1, sof_first && x == 0 && y == 0, img[f][y][x]);
                if (x >= 2 && y >= 2)
                    exp_q.push_back(win(f, x, y));
                n = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
                for (int g = 0; g < n; g++) begin
                    step(1'b0, 1'b0, 8'h00);
                    @(negedge clk);
                    chk("gap_valid", {79'd0, out_valid}, 80'd0);
                    chk("gap_hold_p8", {72'd0, p8}, {72'd0, img[f][y][x]});
                end
            end
        end
    endtask

    task automatic clear_q();
        cap.delete();
        exp_q.delete();
    endtask

    task automatic finish_check(input string tag);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk({tag, "_count"}, 80'(cap.size()), 80'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
            chk({tag, "_win"}, {7'd0, cap[i]}, {7'd0, exp_q[i]});
    endtask

    initial begin
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                img[0][y][x] = 8'(16*y + x);
                img[1][y][x] = 8'(8'h40 + 16*y + x);
                img[2][y][x] = 8'(8'h80 + 16*y + x);
                img[3][y][x] = 8'($urandom_range(0, 255));
                img[4][y][x] = 8'($urandom_range(0, 255));
            end
        end

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_pixel = 8'h00;

        // Reset held while the input toggles.
        for (int i = 0; i < 6; i++)
            step(i[0], i == 0, 8'(8'hA5 + i));
        @(negedge clk);
        chk("rst_valid", {79'd0, out_valid}, 80'd0);
        chk("rst_last", {79'd0, out_last}, 80'd0);
        chk("rst_p", {8'd0, p0, p1, p2, p3, p4, p5, p6, p7, p8}, 80'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 8'h00);

        // Basic frame, continuous input.
        clear_q();
        send_frame(0, 1'b1, 0);
        finish_check("basic");
        chk("basic_n", 80'(cap.size()), 80'd2);
        if (cap.size() >= 2) begin
            chk("basic_w0", {7'd0, cap[0]}, {7'd0, 1'b0, 72'h00_01_02_10_11_12_20_21_22});
            chk("basic_w1", {7'd0, cap[1]}, {7'd0, 1'b1, 72'h01_02_03_11_12_13_21_22_23});
        end

        // Same frame with an idle cycle after every pixel.
        clear_q();
        send_frame(0, 1'b1, 1);
        finish_check("gapped");

        // Two frames back to back, second without in_sof.
        clear_q();
        send_frame(0, 1'b1, 0);
        send_frame(1, 1'b0, 0);
        finish_check("b2b");
        chk("b2b_n", 80'(cap.size()), 80'd4);
        if (cap.size() >= 3)
            chk("b2b_f2_p0", {72'd0, cap[2][71:64]}, 80'h40);

        // Mid-frame resync: seven stale pixels, then a fresh frame with in_sof.
        clear_q();
        for (int i = 0; i < 7; i++)
            step(1'b1, i == 0, 8'(8'hF0 + i));
        send_frame(2, 1'b1, 0);
        finish_check("resync");
        chk("resync_n", 80'(cap.size()), 80'd2);
        if (cap.size() >= 1) begin
            chk("resync_p0", {72'd0, cap[0][71:64]}, 80'h80);
            chk("resync_p8", {72'd0, cap[0][7:0]}, 80'hA2);
        end

        // Reset mid-frame clears outputs at once; next pixel is (0,0) without sof.
        clear_q();
        for (int i = 0; i < 9; i++)
            step(1'b1, i == 0, img[0][i / W][i % W]);
        chk("pre_rst_p8", {72'd0, p8}, 80'h20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_p", {8'd0, p0, p1, p2, p3, p4, p5, p6, p7, p8}, 80'd0);
        chk("async_rst_valid", {79'd0, out_valid}, 80'd0);
        step(1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        clear_q();
        send_frame(1, 1'b0, 0);
        finish_check("post_rst");

        // Random pixels, two frames, random gaps.
        clear_q();
        send_frame(3, 1'b1, 2);
        send_frame(4, 1'b0, 2);
        finish_check("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
